// File: rtl/mcu_nios2_gen2_0_cpu_debug_mem_arbiter.sv
// Debug RAM arbiter: shares the single-port OCI/monitor RAM between the
// JTAG debug command path (take_action pulses + jdo) and the CPU Avalon
// debug_mem slave. JTAG work sits in a one-deep pending slot; Avalon
// requests are taken straight from the bus while the FSM is idle.
module mcu_nios2_gen2_0_cpu_debug_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AV_RD  = 2'd1,
    AV_ACK = 2'd2,
    JT_RD  = 2'd3
  } state_t;

  localparam logic LG_AVALON = 1'b0;
  localparam logic LG_JTAG   = 1'b1;

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   jtag_addr_r;
  logic                jt_pend_r;
  logic                jt_pend_wr_r;
  logic [DATA_W-1:0]   jt_wdata_r;
  logic                last_grant_r;
  logic                overrun_r;
  logic                waitreq_r;
  logic [DATA_W-1:0]   readdata_r;
  logic [DATA_W-1:0]   mon_dreg_r;

  logic                av_pend_s;
  logic                grant_av_s;
  logic                grant_jt_s;
  logic                jt_done_s;
  logic                busy_s;
  logic                accept_s;
  logic                rd_req_s;
  logic                wr_req_s;
  logic                new_cmd_s;
  logic                drop_s;
  logic                addr_load_s;
  logic                jdo_unused_s;

  // Command bits outside the address/data fields carry nothing for this block.
  assign jdo_unused_s = ^{jdo[37:35], jdo[2:0]};

  assign av_pend_s = avs_read | avs_write;

  // Busy comes from registered state only, so a command finishing this cycle
  // frees the slot for a pulse arriving in the same cycle.
  assign busy_s    = jt_pend_r | (state_r == JT_RD);
  assign jt_done_s = (state_r == JT_RD) | (grant_jt_s & jt_pend_wr_r);
  assign accept_s  = ~busy_s | jt_done_s;

  assign rd_req_s    = (take_action_ocimem_a & jdo[34]) | take_no_action_ocimem_a;
  assign wr_req_s    = take_action_ocimem_b;
  assign new_cmd_s   = (rd_req_s | wr_req_s) & accept_s;
  assign drop_s      = (rd_req_s | wr_req_s) & ~accept_s;
  // An address-only load is never refused; a load-and-read is all-or-nothing.
  assign addr_load_s = take_action_ocimem_a & (~jdo[34] | accept_s);

  assign avs_waitrequest = waitreq_r;
  assign avs_readdata    = readdata_r;
  assign MonDReg         = mon_dreg_r;
  assign jtag_busy       = busy_s;
  assign jtag_overrun    = overrun_r;

  // Idle-only arbitration; a tie goes to the side that did not win last.
  always_comb begin
    grant_av_s = 1'b0;
    grant_jt_s = 1'b0;
    if (state_r == IDLE) begin
      if (av_pend_s && jt_pend_r) begin
        if (last_grant_r == LG_AVALON) begin
          grant_jt_s = 1'b1;
        end else begin
          grant_av_s = 1'b1;
        end
      end else if (av_pend_s) begin
        grant_av_s = 1'b1;
      end else if (jt_pend_r) begin
        grant_jt_s = 1'b1;
      end else begin
        grant_av_s = 1'b0;
      end
    end else begin
      grant_jt_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; JTAG writes finish in IDLE without a visit elsewhere.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (grant_av_s) begin
          state_next_s = avs_read ? AV_RD : AV_ACK;
        end else if (grant_jt_s) begin
          state_next_s = jt_pend_wr_r ? IDLE : JT_RD;
        end else begin
          state_next_s = IDLE;
        end
      end
      AV_RD:   state_next_s = AV_ACK;
      AV_ACK:  state_next_s = IDLE;
      JT_RD:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: RAM port steered by the current grant; read wins over write.
  always_comb begin
    ram_addr   = jtag_addr_r;
    ram_we     = 1'b0;
    ram_byteen = 4'hF;
    ram_wdata  = jt_wdata_r;
    if (grant_av_s) begin
      ram_addr   = avs_address;
      ram_we     = avs_write & ~avs_read;
      ram_byteen = avs_byteenable;
      ram_wdata  = avs_writedata;
    end else if (grant_jt_s) begin
      ram_we = jt_pend_wr_r;
    end else begin
      ram_we = 1'b0;
    end
  end

  // Avalon handshake and the two read-data holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitreq_r  <= 1'b1;
      readdata_r <= {DATA_W{1'b0}};
      mon_dreg_r <= {DATA_W{1'b0}};
    end else begin
      waitreq_r <= (state_next_s != AV_ACK);
      if (state_r == AV_RD) begin
        readdata_r <= ram_rdata;
      end
      if (state_r == JT_RD) begin
        mon_dreg_r <= ram_rdata;
      end
    end
  end

  // JTAG address, pending slot, overrun flag and grant history.
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_addr_r  <= {ADDR_W{1'b0}};
      jt_pend_r    <= 1'b0;
      jt_pend_wr_r <= 1'b0;
      jt_wdata_r   <= {DATA_W{1'b0}};
      overrun_r    <= 1'b0;
      last_grant_r <= LG_AVALON;
    end else begin
      if (addr_load_s) begin
        jtag_addr_r <= jdo[ADDR_W+16:17];
      end else if (jt_done_s) begin
        jtag_addr_r <= jtag_addr_r + ADDR_W'(1);
      end
      if (new_cmd_s) begin
        jt_pend_r    <= 1'b1;
        jt_pend_wr_r <= wr_req_s;
        if (wr_req_s) begin
          jt_wdata_r <= jdo[34:3];
        end
      end else if (jt_done_s) begin
        jt_pend_r <= 1'b0;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (addr_load_s) begin
        overrun_r <= 1'b0;
      end
      if (grant_av_s) begin
        last_grant_r <= LG_AVALON;
      end else if (grant_jt_s) begin
        last_grant_r <= LG_JTAG;
      end
    end
  end

endmodule

// File: tb/tb_mcu_nios2_gen2_0_cpu_debug_mem_arbiter.sv
// Scoreboard bench for the debug RAM arbiter: stimulus pushes expected
// Avalon completions and MonDReg values; a negedge monitor checks them.
module tb_mcu_nios2_gen2_0_cpu_debug_mem_arbiter;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              jtag_busy;
  logic              jtag_overrun;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_byteen;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  mcu_nios2_gen2_0_cpu_debug_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Debug RAM model: byte-enabled write, registered read.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_byteen);
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t av_q[$];
  exp_t jt_q[$];
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  function void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every Avalon ack must match the head of the queue; MonDReg checked at its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!avs_waitrequest) begin
        if (av_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL avs_unexpected_ack: waitrequest low at cycle %0d, expected high", cyc);
        end else begin
          e = av_q.pop_front();
          check("avs_ack_cycle", 32'(cyc), 32'(e.due));
          if (e.rd) check("avs_readdata", avs_readdata, e.data);
        end
      end else if (av_q.size() != 0 && cyc > av_q[0].due) begin
        e = av_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL avs_ack_timeout: no ack by cycle %0d, expected at cycle %0d", cyc, e.due);
      end
      if (jt_q.size() != 0 && cyc == jt_q[0].due) begin
        e = jt_q.pop_front();
        check("MonDReg", MonDReg, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) tick();
  endtask

  function automatic logic [37:0] jdo_addr(logic [7:0] a, logic rd);
    logic [37:0] j;
    j = 38'd0;
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(logic [31:0] d);
    logic [37:0] j;
    j = 38'd0;
    j[34:3] = d;
    return j;
  endfunction

  // kind 0: ocimem_a, 1: no_action_ocimem_a, 2: ocimem_b
  task automatic pulse(int kind, logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic expect_mon(int lat, logic [31:0] d);
    exp_t e;
    e.due = cyc + lat;
    e.rd = 1'b1;
    e.data = d;
    jt_q.push_back(e);
  endtask

  // Avalon master: hold request until waitrequest is seen low, then release.
  task automatic av_xfer(bit rd, logic [7:0] a, logic [31:0] wd, logic [3:0] be, int lat, logic [31:0] exp_d);
    exp_t e;
    e.due = cyc + lat;
    e.rd = rd;
    e.data = exp_d;
    av_q.push_back(e);
    avs_address = a;
    avs_writedata = wd;
    avs_byteenable = be;
    avs_read = rd;
    avs_write = ~rd;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
    end
    tick();
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    jdo = 38'd0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avs_address = 8'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = 32'd0;
    avs_byteenable = 4'h0;
    wait_cycles(3);
    @(negedge clk);
    check("reset_waitrequest", 32'(avs_waitrequest), 32'd1);
    check("reset_readdata", avs_readdata, 32'd0);
    check("reset_MonDReg", MonDReg, 32'd0);
    check("reset_busy", 32'(jtag_busy), 32'd0);
    check("reset_overrun", 32'(jtag_overrun), 32'd0);
    check("reset_ram_we", 32'(ram_we), 32'd0);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // JTAG address load, write, read-back, then streaming read at the incremented address.
    pulse(0, jdo_addr(8'h10, 1'b0));
    wait_cycles(3);
    pulse(2, jdo_data(32'hDEADBEEF));
    wait_cycles(3);
    expect_mon(3, 32'hDEADBEEF);
    pulse(0, jdo_addr(8'h10, 1'b1));
    wait_cycles(4);
    expect_mon(3, 32'hC0DE0011);
    pulse(1, 38'd0);
    wait_cycles(4);

    // Avalon full-word write/read, then partial byte-enable write/read.
    av_xfer(1'b0, 8'h20, 32'h12345678, 4'hF, 1, 32'd0);
    av_xfer(1'b1, 8'h20, 32'd0, 4'hF, 2, 32'h12345678);
    av_xfer(1'b0, 8'h20, 32'hAABBCCDD, 4'b0101, 1, 32'd0);
    av_xfer(1'b1, 8'h20, 32'd0, 4'hF, 2, 32'h12BB56DD);
    wait_cycles(2);

    // Arbitration ties: fresh reset -> JTAG first; after an Avalon grant -> JTAG again;
    // after a lone JTAG grant -> Avalon first.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_mon(4, 32'hC0DE0000);
    pulse(1, 38'd0);
    av_xfer(1'b1, 8'h20, 32'd0, 4'hF, 4, 32'h12BB56DD);
    expect_mon(4, 32'hC0DE0001);
    pulse(1, 38'd0);
    av_xfer(1'b1, 8'h20, 32'd0, 4'hF, 4, 32'h12BB56DD);
    wait_cycles(2);
    expect_mon(3, 32'hC0DE0002);
    pulse(1, 38'd0);
    wait_cycles(3);
    expect_mon(6, 32'hC0DE0003);
    pulse(1, 38'd0);
    av_xfer(1'b1, 8'h20, 32'd0, 4'hF, 2, 32'h12BB56DD);
    wait_cycles(3);

    // Address wrap, dropped pulse while busy, pulse accepted on the completing cycle.
    pulse(0, jdo_addr(8'hFF, 1'b0));
    wait_cycles(3);
    expect_mon(3, 32'hC0DE00FF);
    pulse(1, 38'd0);
    pulse(1, 38'd0);
    expect_mon(3, 32'hC0DE0000);
    pulse(1, 38'd0);
    @(negedge clk);
    check("busy_pending", 32'(jtag_busy), 32'd1);
    check("overrun_set", 32'(jtag_overrun), 32'd1);
    wait_cycles(3);
    @(negedge clk);
    check("overrun_sticky", 32'(jtag_overrun), 32'd1);
    check("busy_idle", 32'(jtag_busy), 32'd0);
    pulse(0, jdo_addr(8'h05, 1'b0));
    @(negedge clk);
    check("overrun_cleared", 32'(jtag_overrun), 32'd0);
    tick();
    expect_mon(3, 32'hC0DE0005);
    pulse(1, 38'd0);
    wait_cycles(4);

    // Reset while in AV_RD; the held read is re-arbitrated and completes.
    fork
      av_xfer(1'b1, 8'h20, 32'd0, 4'hF, 4, 32'h12BB56DD);
      begin
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_waitrequest", 32'(avs_waitrequest), 32'd1);
        check("rst_mid_MonDReg", MonDReg, 32'd0);
        check("rst_mid_readdata", avs_readdata, 32'd0);
        check("rst_mid_busy", 32'(jtag_busy), 32'd0);
      end
    join
    wait_cycles(5);
    check("queues_drained", 32'(av_q.size() + jt_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
